// File: rtl/sha_pkg.sv
// Shared constants, digest type and scheduler state encoding for the
// nonce scheduler and its splice helper.
package sha_pkg;

  localparam int BLK_W     = 512;
  localparam int HASH_W    = 256;
  localparam int NONCE_LSB = 384;

  typedef logic [HASH_W-1:0] digest_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_FOUND   = 3'd4,
    S_EXHAUST = 3'd5,
    S_DRAIN   = 3'd6
  } sched_state_e;

endpackage

// File: rtl/nonce_splice.sv
// Combinational insertion of a 32-bit nonce into a block template.
// The template's own nonce field content is discarded.
module nonce_splice
  import sha_pkg::*;
#(
  parameter int BLK_W     = sha_pkg::BLK_W,
  parameter int NONCE_LSB = sha_pkg::NONCE_LSB
) (
  input  logic [BLK_W-1:0] tmpl,
  input  logic [31:0]      nonce,
  output logic [BLK_W-1:0] block
);

  // Copy the template, then overwrite the nonce word.
  always_comb begin
    block = tmpl;
    block[NONCE_LSB +: 32] = nonce;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Sweeps a nonce window through the SHA-256 core one hash at a time and
// reports the first digest below target, or exhaustion of the window.
//
// Core handshake: sha_start is a one-cycle pulse; sha_block is held stable
// from that pulse until sha_done. sha_hash is only valid with sha_done.
// The core is never restarted until it has returned sha_done, so an abort
// while a hash is in flight parks in DRAIN until the result is discarded.
module nonce_scheduler
  import sha_pkg::*;
#(
  parameter int BLK_W     = sha_pkg::BLK_W,
  parameter int HASH_W    = sha_pkg::HASH_W,
  parameter int NONCE_LSB = sha_pkg::NONCE_LSB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [BLK_W-1:0]  cfg_block,
  input  logic [31:0]       cfg_nonce_start,
  input  logic [31:0]       cfg_nonce_end,
  input  logic [HASH_W-1:0] cfg_target,
  input  logic              abort,
  input  logic              result_ack,
  output logic              sha_start,
  output logic [BLK_W-1:0]  sha_block,
  input  logic [HASH_W-1:0] sha_hash,
  input  logic              sha_done,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic [31:0]       found_nonce,
  output logic [HASH_W-1:0] found_hash,
  output logic [31:0]       hash_count,
  output logic [2:0]        dbg_state
);

  sched_state_e      state, state_nx;
  logic [BLK_W-1:0]  tmpl_r;
  logic [31:0]       nonce_r;
  logic [31:0]       end_r;
  logic [HASH_W-1:0] target_r;
  logic [HASH_W-1:0] hash_reg;
  logic              hit;
  logic [BLK_W-1:0]  splice_tmpl;
  logic [BLK_W-1:0]  splice_out;
  logic [31:0]       splice_nonce;

  assign hit = (hash_reg < target_r);

  // The block is built for the nonce about to be issued: the fresh config
  // when launching from IDLE, otherwise the latched template and nonce + 1.
  assign splice_tmpl  = (state == S_IDLE) ? cfg_block       : tmpl_r;
  assign splice_nonce = (state == S_IDLE) ? cfg_nonce_start : nonce_r + 32'd1;

  nonce_splice #(
    .BLK_W     (BLK_W),
    .NONCE_LSB (NONCE_LSB)
  ) u_splice (
    .tmpl  (splice_tmpl),
    .nonce (splice_nonce),
    .block (splice_out)
  );

  // Next-state logic; abort has priority over every other event.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (cfg_valid) state_nx = S_ISSUE;
      S_ISSUE:   state_nx = abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (abort)         state_nx = sha_done ? S_IDLE : S_DRAIN;
        else if (sha_done) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (abort)                 state_nx = S_IDLE;
        else if (hit)              state_nx = S_FOUND;
        else if (nonce_r == end_r) state_nx = S_EXHAUST;
        else                       state_nx = S_ISSUE;
      end
      S_FOUND, S_EXHAUST: if (abort || result_ack) state_nx = S_IDLE;
      S_DRAIN:   if (sha_done) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // State, job registers, core block and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tmpl_r      <= '0;
      nonce_r     <= '0;
      end_r       <= '0;
      target_r    <= '0;
      hash_reg    <= '0;
      sha_block   <= '0;
      found_nonce <= '0;
      found_hash  <= '0;
      hash_count  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == S_ISSUE) sha_block <= splice_out;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            tmpl_r     <= cfg_block;
            end_r      <= cfg_nonce_end;
            target_r   <= cfg_target;
            nonce_r    <= cfg_nonce_start;
            hash_count <= '0;
          end
        end
        S_WAIT: begin
          if (state_nx == S_CHECK) begin
            hash_reg   <= sha_hash;
            hash_count <= hash_count + 32'd1;
          end
        end
        S_CHECK: begin
          if (state_nx == S_FOUND) begin
            found_nonce <= nonce_r;
            found_hash  <= hash_reg;
          end
          if (state_nx == S_ISSUE) nonce_r <= nonce_r + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign sha_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign found     = (state == S_FOUND);
  assign exhausted = (state == S_EXHAUST);
  assign dbg_state = state;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: a behavioural core model checks every issued
// block against a queue of expected nonces, a vector table runs whole jobs,
// and hand-written sequences cover abort, drain and reset corners.
module tb_nonce_scheduler;
  import sha_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic [BLK_W-1:0]  cfg_block;
  logic [31:0]       cfg_nonce_start;
  logic [31:0]       cfg_nonce_end;
  digest_t           cfg_target;
  logic              abort;
  logic              result_ack;
  logic              sha_start;
  logic [BLK_W-1:0]  sha_block;
  digest_t           sha_hash;
  logic              sha_done;
  logic              busy;
  logic              found;
  logic              exhausted;
  logic [31:0]       found_nonce;
  digest_t           found_hash;
  logic [31:0]       hash_count;
  logic [2:0]        dbg_state;

  // core model and hand-driven core signals are merged here
  logic              m_done, h_done;
  digest_t           m_hash, h_hash;
  assign sha_done = m_done | h_done;
  assign sha_hash = m_done ? m_hash : h_hash;

  nonce_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_block       (cfg_block),
    .cfg_nonce_start (cfg_nonce_start),
    .cfg_nonce_end   (cfg_nonce_end),
    .cfg_target      (cfg_target),
    .abort           (abort),
    .result_ack      (result_ack),
    .sha_start       (sha_start),
    .sha_block       (sha_block),
    .sha_hash        (sha_hash),
    .sha_done        (sha_done),
    .busy            (busy),
    .found           (found),
    .exhausted       (exhausted),
    .found_nonce     (found_nonce),
    .found_hash      (found_hash),
    .hash_count      (hash_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0]      exp_q[$];
  logic [BLK_W-1:0] cur_tmpl;
  logic [31:0]      cur_hit;
  bit               model_on = 1'b0;
  int               done_cyc = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SHA core: digest 1 for the designated hit nonce, otherwise a
  // value with the MSB set (above any small target, below all-ones).
  initial begin
    logic [31:0]      n, en;
    logic [BLK_W-1:0] exp_blk;
    int               lat;
    m_done = 1'b0;
    m_hash = '0;
    forever begin
      @(posedge clk); #1;
      if (model_on && sha_start) begin
        n = sha_block[NONCE_LSB +: 32];
        exp_blk = cur_tmpl;
        if (exp_q.size() == 0) begin
          check("unexpected_sha_start", 256'(n), 256'hDEAD);
        end else begin
          en = exp_q.pop_front();
          check("issue_nonce", 256'(n), 256'(en));
          exp_blk[NONCE_LSB +: 32] = en;
          check("issue_block", 256'(sha_block ^ exp_blk), 256'd0);
        end
        lat = $urandom_range(1, 4);
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
          if (sha_start || sha_block !== exp_blk)
            check("core_busy_hold", {254'd0, sha_start, sha_block !== exp_blk}, 256'd0);
        end
        m_hash = '0;
        if (n == cur_hit) m_hash = 256'd1;
        else begin
          m_hash[HASH_W-1] = 1'b1;
          m_hash[31:0]     = n;
        end
        m_done   = 1'b1;
        done_cyc = cyc;
        @(posedge clk); #1;
        m_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input digest_t t);
    for (int i = 0; i < BLK_W / 32; i++) cur_tmpl[i*32 +: 32] = $urandom();
    cfg_block       = cur_tmpl;
    cfg_nonce_start = s;
    cfg_nonce_end   = e;
    cfg_target      = t;
    cfg_valid       = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("start_latency", 256'(sha_start), 256'd1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    digest_t     target;
    logic [31:0] hit;
    bit          poke;
    bit          exp_found;
    logic [31:0] exp_nonce;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [31:0] n;
    int          t;
    v = vecs[idx];
    cur_hit = v.hit;
    n = v.start;
    for (int i = 0; i < int'(v.exp_count); i++) begin
      exp_q.push_back(n);
      n = n + 32'd1;
    end
    start_job(v.start, v.stop, v.target);
    if (v.poke) begin
      tick();
      cfg_block       = ~cur_tmpl;
      cfg_nonce_start = 32'd999;
      cfg_nonce_end   = 32'd999;
      cfg_target      = '1;
      cfg_valid       = 1'b1;
      tick();
      cfg_valid = 1'b0;
    end
    t = 0;
    while (!(found || exhausted) && t < 500) begin
      tick();
      t++;
    end
    check("result_timeout", 256'(t >= 500), 256'd0);
    check("result_latency", 256'(cyc - done_cyc), 256'd2);
    check("found", 256'(found), 256'(v.exp_found));
    check("exhausted", 256'(exhausted), 256'(!v.exp_found));
    check("hash_count", 256'(hash_count), 256'(v.exp_count));
    check("all_issued", 256'(exp_q.size()), 256'd0);
    if (v.exp_found) begin
      check("found_nonce", 256'(found_nonce), 256'(v.exp_nonce));
      check("found_hash", found_hash, 256'd1);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack_busy", {254'd0, busy, found | exhausted}, 256'd0);
    check("ack_count_hold", 256'(hash_count), 256'(v.exp_count));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    digest_t all1;
    bit      bad;
    all1 = '1;
    reset = 1'b1; cfg_valid = 1'b0; cfg_block = '0; cfg_nonce_start = '0;
    cfg_nonce_end = '0; cfg_target = '0; abort = 1'b0; result_ack = 1'b0;
    h_done = 1'b0; h_hash = '0; cur_tmpl = '0; cur_hit = '0;

    //          start         stop          target  hit            poke fnd nonce         count
    vecs[0] = '{32'd0,        32'd9,        all1,   32'd0,         0,   1,  32'd0,        32'd1};
    vecs[1] = '{32'd5,        32'd7,        '0,     32'd0,         0,   0,  32'd0,        32'd3};
    vecs[2] = '{32'd0,        32'd3,        256'd2, 32'd3,         0,   1,  32'd3,        32'd4};
    vecs[3] = '{32'hFFFFFFFE, 32'h00000001, 256'd2, 32'd5,         0,   0,  32'd0,        32'd4};
    vecs[4] = '{32'd10,       32'd10,       256'd2, 32'd10,        0,   1,  32'd10,       32'd1};
    vecs[5] = '{32'd20,       32'd20,       '0,     32'd0,         0,   0,  32'd0,        32'd1};
    vecs[6] = '{32'd100,      32'd120,      256'd2, 32'd107,       1,   1,  32'd107,      32'd8};

    repeat (3) tick();
    reset = 1'b0;
    check("reset_outputs", {250'd0, sha_start, busy, found, exhausted, 2'b00}, 256'd0);
    check("reset_regs", 256'(|{sha_block, found_nonce, found_hash, hash_count, dbg_state}), 256'd0);

    // abort two cycles after sha_start lands in DRAIN; core is not restarted
    start_job(32'd0, 32'd9, '0);
    check("a_issue_nonce", 256'(sha_block[NONCE_LSB +: 32]), 256'd0);
    tick();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    check("a_drain_state", 256'(dbg_state), 256'(S_DRAIN));
    bad = 1'b0;
    repeat (3) begin tick(); if (sha_start || !busy) bad = 1'b1; end
    check("a_drain_quiet", 256'(bad), 256'd0);
    h_done = 1'b1; h_hash = 256'd1;
    tick(); h_done = 1'b0;
    check("a_idle", {253'd0, busy, found, dbg_state != 3'(S_IDLE)}, 256'd0);

    // abort together with sha_done in WAIT goes straight to IDLE
    start_job(32'd0, 32'd9, '0);
    tick(); abort = 1'b1; h_done = 1'b1;
    tick(); abort = 1'b0; h_done = 1'b0;
    check("b_idle", {254'd0, busy, dbg_state != 3'(S_IDLE)}, 256'd0);

    // hit, then abort and result_ack together return to IDLE
    start_job(32'd3, 32'd9, all1);
    tick(); h_done = 1'b1; h_hash = 256'd1;
    tick(); h_done = 1'b0;
    tick();
    check("c_found", 256'(found), 256'd1);
    check("c_found_nonce", 256'(found_nonce), 256'd3);
    abort = 1'b1; result_ack = 1'b1;
    tick(); abort = 1'b0; result_ack = 1'b0;
    check("c_abort_ack", {254'd0, busy, found}, 256'd0);

    // reset while in CHECK clears everything on the next cycle
    start_job(32'd7, 32'd9, '0);
    tick(); h_done = 1'b1; h_hash = 256'd5;
    tick(); h_done = 1'b0;
    check("d_in_check", 256'(dbg_state), 256'(S_CHECK));
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("d_reset_outputs", {252'd0, sha_start, busy, found, exhausted}, 256'd0);
    check("d_reset_regs", 256'(|{sha_block, found_nonce, found_hash, hash_count, dbg_state}), 256'd0);

    // full jobs against the core model
    model_on = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(i);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if something wedges beyond every bounded wait.
  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
